vec_reg_bank: RTL and testbench

- Vector register bank of 16 registers, each M lanes x N bits.
- Directly upstream of the 16:1 vector operand mux: all 16 registers are presented in parallel on regs_out, one slice per mux data input (index k drives the mux input selected by sel=k).
- Supports lane-masked writes, scalar-broadcast writes, and a sequenced 16-cycle bulk clear with a busy/done handshake.

---
 rtl/vec_pkg.sv | 18 +
 rtl/vec_lane_write.sv | 28 ++
 rtl/vec_reg_bank.sv | 107 ++++++++++
 tb/tb_vec_reg_bank.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector register bank.
//   NUM_VREGS / VREG_AW : register count and address width.
//   vec_t               : one vector at default geometry (16 lanes x 16 bits).
//   clr_state_t         : bulk-clear sequencer states.
package vec_pkg;

  localparam int NUM_VREGS = 16;
  localparam int VREG_AW   = 4;

  typedef logic [15:0][15:0] vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/vec_lane_write.sv
// Combinational next-value builder for one vector register.
// Ports:
//   old_i   : current register contents
//   wdata_i : write vector
//   wmask_i : per-lane enable, bit i gates lane i
//   bcast_i : replicate wdata_i[0] to every lane before masking
//   new_o   : merged next value
module vec_lane_write #(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic [M-1:0][N-1:0] old_i,
  input  logic [M-1:0][N-1:0] wdata_i,
  input  logic [M-1:0]        wmask_i,
  input  logic                bcast_i,
  output logic [M-1:0][N-1:0] new_o
);

  always_comb begin
    new_o = old_i;
    for (int i = 0; i < M; i++) begin
      if (wmask_i[i]) begin
        new_o[i] = bcast_i ? wdata_i[0] : wdata_i[i];
      end
    end
  end

endmodule

// File: rtl/vec_reg_bank.sv
// Vector register bank: 16 registers of M lanes x N bits, all presented in
// parallel on regs_out (slice k feeds operand-mux input k).
// Ports:
//   clk, rst  : rising-edge clock, async active-high reset
//   we/waddr/wdata/wmask/bcast : lane-masked, optionally broadcast write
//   clr_req   : level request for a 16-cycle bulk clear (sampled in IDLE)
//   clr_busy  : high while the clear sequence runs
//   clr_done  : one-cycle pulse when the clear finishes
//   regs_out  : storage flops, no read mux
//   dbg_state : current sequencer state
//
// Handshake: a write is a single-cycle request with no ready signal; it is
// accepted on any edge where clr_busy is low and silently dropped while
// clr_busy is high, so upstream must watch clr_busy and hold or reissue.
module vec_reg_bank
  import vec_pkg::*;
#(
  parameter int N       = 16,
  parameter int M       = 16,
  parameter int ZERO_R0 = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [3:0]                   waddr,
  input  logic [M-1:0][N-1:0]          wdata,
  input  logic [M-1:0]                 wmask,
  input  logic                         bcast,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic                         clr_done,
  output logic [15:0][M-1:0][N-1:0]    regs_out,
  output logic [1:0]                   dbg_state
);

  logic [NUM_VREGS-1:0][M-1:0][N-1:0] regs_q, regs_d;
  clr_state_t                         state_q, state_d;
  logic [VREG_AW-1:0]                 cnt_q, cnt_d;
  logic                               busy_q, done_q;
  logic [M-1:0][N-1:0]                lane_new;
  logic                               wr_en;

  // Register 0 is hardwired to zero in the ZERO_R0 build, so its writes
  // are dropped here rather than masked at the output alone.
  assign wr_en = we && !((ZERO_R0 != 0) && (waddr == '0));

  vec_lane_write #(.N(N), .M(M)) u_lane_write (
    .old_i   (regs_q[waddr]),
    .wdata_i (wdata),
    .wmask_i (wmask),
    .bcast_i (bcast),
    .new_o   (lane_new)
  );

  always_comb begin
    regs_d  = regs_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A write and a clear request on the same edge both take effect;
        // the freshly written register is zeroed later by the sweep.
        if (wr_en) regs_d[waddr] = lane_new;
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + 1'b1;  // wraps 15 -> 0 on exit
        if (cnt_q == '1) state_d = DONE;
      end
      DONE: begin
        if (wr_en) regs_d[waddr] = lane_new;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == CLEAR);
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    regs_out = regs_q;
    if (ZERO_R0 != 0) regs_out[0] = '0;
  end

  assign clr_busy  = busy_q;
  assign clr_done  = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vec_reg_bank.sv
module tb_vec_reg_bank;

  localparam int N  = 16;
  localparam int M  = 16;
  localparam int VW = N * M;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                      we;
  logic [3:0]                waddr;
  logic [M-1:0][N-1:0]       wdata;
  logic [M-1:0]              wmask;
  logic                      bcast;
  logic                      clr_req;
  logic                      busy0, done0, busy1, done1;
  logic [15:0][M-1:0][N-1:0] regs0, regs1;
  logic [1:0]                dbg0, dbg1;

  vec_reg_bank #(.N(N), .M(M), .ZERO_R0(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .wmask(wmask), .bcast(bcast), .clr_req(clr_req), .clr_busy(busy0),
    .clr_done(done0), .regs_out(regs0), .dbg_state(dbg0)
  );

  vec_reg_bank #(.N(N), .M(M), .ZERO_R0(1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .wmask(wmask), .bcast(bcast), .clr_req(clr_req), .clr_busy(busy1),
    .clr_done(done1), .regs_out(regs1), .dbg_state(dbg1)
  );

  // ---------------- reference model ----------------
  // Registers as flat vectors; clear sweep tracked as "next register to
  // zero" (-1 when no sweep is running) plus a done flag.
  logic [VW-1:0] mreg0 [16];
  logic [VW-1:0] mreg1 [16];
  int            clr_pos;
  bit            in_done;
  int            busy_cnt, done_cnt;

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] merge(input logic [VW-1:0] old);
    logic [VW-1:0] r;
    r = old;
    for (int i = 0; i < M; i++)
      if (wmask[i]) r[i*N +: N] = bcast ? wdata[0] : wdata[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      mreg0[k] = '0;
      mreg1[k] = '0;
    end
    clr_pos = -1;
    in_done = 1'b0;
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 16; k++) exp_q.push_back(mreg0[k]);
    for (int k = 0; k < 16; k++) exp_q.push_back(mreg1[k]);
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_d0_r%0d", ph, k), regs0[k], exp_q.pop_front());
    for (int k = 0; k < 16; k++)
      check($sformatf("%s_d1_r%0d", ph, k), regs1[k], exp_q.pop_front());
    check({ph, "_busy0"}, VW'(busy0), VW'(clr_pos >= 0));
    check({ph, "_done0"}, VW'(done0), VW'(in_done));
    check({ph, "_busy1"}, VW'(busy1), VW'(clr_pos >= 0));
    check({ph, "_done1"}, VW'(done1), VW'(in_done));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0; wmask = '0; bcast = 1'b0; clr_req = 1'b0;
  endtask

  task automatic set_write(input int a, input logic [N-1:0] v, input logic [M-1:0] m, input bit b);
    we = 1'b1; waddr = 4'(a); wmask = m; bcast = b;
    for (int i = 0; i < M; i++) wdata[i] = v;
  endtask

  // Apply the model update for the coming edge, clock it, check outputs.
  task automatic tick(input string ph);
    if (clr_pos >= 0) begin
      mreg0[clr_pos] = '0;
      mreg1[clr_pos] = '0;
      clr_pos++;
      if (clr_pos == 16) begin
        clr_pos = -1;
        in_done = 1'b1;
      end
    end else begin
      if (we) begin
        mreg0[waddr] = merge(mreg0[waddr]);
        if (waddr != 0) mreg1[waddr] = merge(mreg1[waddr]);
      end
      if (in_done) in_done = 1'b0;
      else if (clr_req) clr_pos = 0;
    end
    @(posedge clk);
    #1;
    if (busy0) busy_cnt++;
    if (done0) done_cnt++;
    check_all(ph);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [VW-1:0] e;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Masked write: lanes 0-7 of reg 3.
    we = 1'b1; waddr = 4'd3; wmask = 16'h00FF; bcast = 1'b0;
    for (int i = 0; i < M; i++) wdata[i] = 16'h0100 + 16'(i);
    tick("mask");
    e = '0;
    for (int i = 0; i < 8; i++) e[i*N +: N] = 16'h0100 + 16'(i);
    check("mask_r3_const", regs0[3], e);

    // Broadcast full and single-lane.
    idle_inputs();
    wdata[0] = 16'hBEEF; we = 1'b1; waddr = 4'd7; wmask = 16'hFFFF; bcast = 1'b1;
    tick("bcast");
    check("bcast_r7_const", regs0[7], {16{16'hBEEF}});
    waddr = 4'd8; wmask = 16'h0001;
    tick("bcast1");
    check("bcast_r8_const", regs0[8], VW'(16'hBEEF));
    idle_inputs();
    wmask = 16'h0000; we = 1'b1; waddr = 4'd7; wdata[0] = 16'h1111;
    tick("nomask");

    // Fill every register, then bulk clear with a dropped write mid-sweep.
    for (int k = 0; k < 16; k++) begin
      set_write(k, 16'hAAAA, 16'hFFFF, 1'b0);
      tick("fill");
    end
    idle_inputs();
    busy_cnt = 0; done_cnt = 0;
    clr_req = 1'b1;
    tick("clr_start");
    clr_req = 1'b0;
    for (int c = 0; c < 17; c++) begin
      if (c == 10) set_write(2, 16'h1234, 16'hFFFF, 1'b0);
      else idle_inputs();
      tick("clr");
      if (c == 10) check("busy_drop_r2", regs0[2], '0);
    end
    check("busy_len", VW'(busy_cnt), VW'(16));
    check("done_pulses", VW'(done_cnt), VW'(1));

    // Simultaneous write and clear request to reg 15.
    busy_cnt = 0; done_cnt = 0;
    set_write(15, 16'h5555, 16'hFFFF, 1'b0);
    clr_req = 1'b1;
    tick("wrclr");
    check("wrclr_r15", regs0[15], {16{16'h5555}});
    idle_inputs();
    for (int c = 0; c < 18; c++) tick("wrclr_seq");
    check("wrclr_r15_zero", regs0[15], '0);
    check("wrclr_done", VW'(done_cnt), VW'(1));

    // Reset in the middle of a clear.
    set_write(4, 16'h7777, 16'hFFFF, 1'b0);
    tick("pre_mid");
    idle_inputs();
    clr_req = 1'b1;
    tick("mid_start");
    clr_req = 1'b0;
    for (int c = 0; c < 5; c++) tick("mid");
    done_cnt = 0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    set_write(2, 16'hC0DE, 16'hFFFF, 1'b0);
    tick("post_rst");
    check("post_rst_r2", regs0[2], {16{16'hC0DE}});
    idle_inputs();
    for (int c = 0; c < 20; c++) tick("post_idle");
    check("mid_no_done", VW'(done_cnt), VW'(0));

    // Register 0 behaviour of the ZERO_R0 build.
    set_write(0, 16'hFFFF, 16'hFFFF, 1'b1);
    tick("zr0");
    check("zr0_d1_r0", regs1[0], '0);
    check("zr0_d0_r0", regs0[0], {16{16'hFFFF}});
    set_write(1, 16'hFFFF, 16'hFFFF, 1'b1);
    tick("zr1");
    check("zr1_d1_r1", regs1[1], {16{16'hFFFF}});

    // Randomized traffic including clears and writes while busy.
    for (int c = 0; c < 400; c++) begin
      we    = ($urandom_range(0, 3) != 0);
      waddr = 4'($urandom_range(0, 15));
      for (int i = 0; i < M; i++) wdata[i] = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       wmask = 16'h0000;
        1:       wmask = 16'hFFFF;
        default: wmask = 16'($urandom);
      endcase
      bcast   = ($urandom_range(0, 3) == 0);
      clr_req = ($urandom_range(0, 24) == 0);
      tick("rand");
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
